dpram_arbiter: RTL and testbench

- Round-robin arbiter sharing one dual_port_ram (two read/write ports, registered read data) among NUM_REQ requesters.
- Grants up to two requests per cycle, one to RAM port A and one to port B.
- Blocks same-address write-write collisions and routes read data back to the issuing requester one cycle after its grant.
- Sits directly in front of the RAM instance. RAM-side ports connect 1:1 to the RAM's addr/data_in/we/data_out pins.

---
 rtl/dpram_arbiter.sv | 145 ++++++++++++++
 tb/tb_dpram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NUM_REQ requesters.
// Issues up to two grants per cycle (port A and port B) and routes read data back to the requester.
module dpram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rdata,
  output logic [ADDR_WIDTH-1:0]            ram_addr_a,
  output logic [ADDR_WIDTH-1:0]            ram_addr_b,
  output logic [DATA_WIDTH-1:0]            ram_din_a,
  output logic [DATA_WIDTH-1:0]            ram_din_b,
  output logic                             ram_we_a,
  output logic                             ram_we_b,
  input  logic [DATA_WIDTH-1:0]            ram_dout_a,
  input  logic [DATA_WIDTH-1:0]            ram_dout_b,
  output logic [CNT_WIDTH-1:0]             conflict_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         own_a, own_b;
  logic                  val_a, val_b;

  logic                  a_found, b_found, collide;
  logic [IW-1:0]         win_a, win_b, last_win, nxt_ptr;
  logic                  a_we, b_we;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0] a_wdata, b_wdata;

  // Single scan from rr_ptr: first requester takes port A, the next one that is not a
  // same-address write pairing with A takes port B; skipped candidates flag a collision.
  always_comb begin
    int unsigned idx;
    a_found = 1'b0;
    b_found = 1'b0;
    collide = 1'b0;
    win_a   = '0;
    win_b   = '0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    a_addr  = '0;
    b_addr  = '0;
    a_wdata = '0;
    b_wdata = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          win_a   = IW'(idx);
          a_we    = req_we[idx];
          a_addr  = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
          a_wdata = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
        end else if (!b_found) begin
          if (a_we && req_we[idx] && (req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] == a_addr)) begin
            collide = 1'b1;
          end else begin
            b_found = 1'b1;
            win_b   = IW'(idx);
            b_we    = req_we[idx];
            b_addr  = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            b_wdata = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
    if (!rst_n) begin
      a_found = 1'b0;
      b_found = 1'b0;
      collide = 1'b0;
    end
  end

  always_comb begin
    last_win = b_found ? win_b : win_a;
    nxt_ptr  = (last_win == IW'(NUM_REQ - 1)) ? '0 : last_win + IW'(1);
  end

  always_comb begin
    gnt        = '0;
    ram_addr_a = '0;
    ram_din_a  = '0;
    ram_we_a   = 1'b0;
    ram_addr_b = '0;
    ram_din_b  = '0;
    ram_we_b   = 1'b0;
    if (a_found) begin
      gnt[win_a] = 1'b1;
      ram_addr_a = a_addr;
      ram_we_a   = a_we;
      ram_din_a  = a_we ? a_wdata : '0;
    end
    if (b_found) begin
      gnt[win_b] = 1'b1;
      ram_addr_b = b_addr;
      ram_we_b   = b_we;
      ram_din_b  = b_we ? b_wdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      val_a        <= 1'b0;
      val_b        <= 1'b0;
      own_a        <= '0;
      own_b        <= '0;
      conflict_cnt <= '0;
    end else begin
      if (a_found) rr_ptr <= nxt_ptr;
      val_a <= a_found && !a_we;
      val_b <= b_found && !b_we;
      own_a <= win_a;
      own_b <= win_b;
      if (collide && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end
  end

  // The RAM already registers its read data, so the owner registers only steer it.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (val_a) begin
      rvalid[own_a]                       = 1'b1;
      rdata[own_a*DATA_WIDTH +: DATA_WIDTH] = ram_dout_a;
    end
    if (val_b) begin
      rvalid[own_b]                       = 1'b1;
      rdata[own_b*DATA_WIDTH +: DATA_WIDTH] = ram_dout_b;
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: behavioural RAM, queue-based arbitration model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dpram_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_we, gnt, rvalid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rdata;
  logic [AW-1:0]   ram_addr_a, ram_addr_b;
  logic [DW-1:0]   ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic            ram_we_a, ram_we_b;
  logic [CW-1:0]   conflict_cnt;
  logic            preload;

  int n_checks = 0;
  int n_fail   = 0;

  dpram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b), .ram_din_a(ram_din_a),
    .ram_din_b(ram_din_b), .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      3:       return 8'h99;
      5:       return 8'h3C;
      default: return 8'hA0 ^ DW'(i);
    endcase
  endfunction

  // Dual-port RAM with registered, read-before-write outputs.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    end
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  // Reference model: list of requesting indices in priority order, then pick A and B.
  int            m_ptr, m_cnt, wa, wb, c, po_a, po_b;
  bit            m_init, cf, pv_a, pv_b;
  logic [DW-1:0] pd_a, pd_b;
  logic [DW-1:0] mdl_mem [16];
  logic [N-1:0]  exp_gnt, exp_rv;
  int            order[$];

  always begin
    @(negedge clk);
    exp_rv = '0;
    if (pv_a) exp_rv[po_a] = 1'b1;
    if (pv_b) exp_rv[po_b] = 1'b1;
    if (m_init) begin
      chk("mdl_rvalid", rvalid, exp_rv);
      if (pv_a) chk("mdl_rdata_a", rdata[po_a*DW +: DW], pd_a);
      if (pv_b) chk("mdl_rdata_b", rdata[po_b*DW +: DW], pd_b);
    end
    if (!rst_n) begin
      chk("mdl_rst_gnt", gnt, 0);
      chk("mdl_rst_we", {ram_we_a, ram_we_b}, 0);
      m_ptr = 0; m_cnt = 0; pv_a = 0; pv_b = 0; m_init = 1;
      if (preload) for (int i = 0; i < 16; i++) mdl_mem[i] = init_val(i);
    end else if (m_init) begin
      chk("mdl_cnt", conflict_cnt, m_cnt);
      order = {};
      for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      wa = -1; wb = -1; cf = 0;
      if (order.size() > 0) begin
        wa = order[0];
        for (int j = 1; j < order.size(); j++) begin
          c = order[j];
          if (req_we[wa] && req_we[c] && addr_of(wa) == addr_of(c)) cf = 1;
          else begin wb = c; break; end
        end
      end
      exp_gnt = '0;
      if (wa >= 0) exp_gnt[wa] = 1'b1;
      if (wb >= 0) exp_gnt[wb] = 1'b1;
      chk("mdl_gnt", gnt, exp_gnt);
      chk("mdl_we_a", ram_we_a, (wa >= 0) && req_we[wa]);
      chk("mdl_we_b", ram_we_b, (wb >= 0) && req_we[wb]);
      chk("mdl_addr_a", ram_addr_a, (wa >= 0) ? addr_of(wa) : 0);
      chk("mdl_addr_b", ram_addr_b, (wb >= 0) ? addr_of(wb) : 0);
      if (wa >= 0 && req_we[wa]) chk("mdl_din_a", ram_din_a, req_wdata[wa*DW +: DW]);
      if (wb >= 0 && req_we[wb]) chk("mdl_din_b", ram_din_b, req_wdata[wb*DW +: DW]);
      pv_a = (wa >= 0) && !req_we[wa];
      pv_b = (wb >= 0) && !req_we[wb];
      po_a = wa; po_b = wb;
      if (pv_a) pd_a = mdl_mem[addr_of(wa)];
      if (pv_b) pd_b = mdl_mem[addr_of(wb)];
      if (wa >= 0 && req_we[wa]) mdl_mem[addr_of(wa)] = req_wdata[wa*DW +: DW];
      if (wb >= 0 && req_we[wb]) mdl_mem[addr_of(wb)] = req_wdata[wb*DW +: DW];
      if (wa >= 0) m_ptr = ((wb >= 0 ? wb : wa) + 1) % N;
      if (cf && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  int gcount [N];
  int lastg  [N];
  int maxgap;

  initial begin
    rst_n = 1'b0; preload = 1'b1; clr();
    repeat (3) cyc();
    #1;
    chk("reset_gnt", gnt, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_cnt", conflict_cnt, 0);
    preload = 1'b0; rst_n = 1'b1;

    // single read, then probe rr_ptr==3 through the next grant pattern
    cyc(); set_req(2, 1'b0, 4'd5, 8'h00); #1;
    chk("single_gnt", gnt, 4'b0100);
    cyc(); clr(); #1;
    chk("single_rvalid", rvalid, 4'b0100);
    chk("single_rdata", rdata[2*DW +: DW], 8'h3C);
    cyc(); for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 8), 8'h00); #1;
    chk("ptr3_gnt", gnt, 4'b1001);
    cyc(); clr(); rst_n = 1'b0;
    cyc(); cyc(); rst_n = 1'b1;

    // dual issue
    cyc(); for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 4), 8'h00); #1;
    chk("dual_gnt1", gnt, 4'b0011);
    cyc(); req[0] = 1'b0; req[1] = 1'b0; #1;
    chk("dual_gnt2", gnt, 4'b1100);
    chk("dual_rv1", rvalid, 4'b0011);
    chk("dual_rd0", rdata[0*DW +: DW], init_val(4));
    chk("dual_rd1", rdata[1*DW +: DW], init_val(5));
    cyc(); clr(); #1;
    chk("dual_rv2", rvalid, 4'b1100);
    chk("dual_rd3", rdata[3*DW +: DW], init_val(7));

    // write-write collision
    cyc(); set_req(0, 1'b1, 4'd7, 8'hAA); set_req(1, 1'b1, 4'd7, 8'h55); #1;
    chk("coll_gnt1", gnt, 4'b0001);
    cyc(); req[0] = 1'b0; #1;
    chk("coll_gnt2", gnt, 4'b0010);
    chk("coll_cnt1", conflict_cnt, 1);
    cyc(); clr(); #1;
    chk("coll_ram7", mem[7], 8'h55);
    chk("coll_cnt", conflict_cnt, 1);

    // write and read of the same address in one cycle
    cyc(); set_req(0, 1'b1, 4'd3, 8'h11); set_req(1, 1'b0, 4'd3, 8'h00); #1;
    chk("wr_gnt", gnt, 4'b0011);
    cyc(); clr(); #1;
    chk("wr_rv", rvalid, 4'b0010);
    chk("wr_old", rdata[1*DW +: DW], 8'h99);
    cyc(); set_req(1, 1'b0, 4'd3, 8'h00); #1;
    chk("wr_gnt2", gnt, 4'b0010);
    cyc(); clr(); #1;
    chk("wr_new", rdata[1*DW +: DW], 8'h11);

    // fairness over 8 cycles
    for (int i = 0; i < N; i++) begin gcount[i] = 0; lastg[i] = -1; end
    maxgap = 0;
    for (int t = 0; t < 8; t++) begin
      cyc(); for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 8'h00); #1;
      for (int i = 0; i < N; i++) if (gnt[i]) begin
        gcount[i]++;
        if (t - lastg[i] > maxgap) maxgap = t - lastg[i];
        lastg[i] = t;
      end
    end
    cyc(); clr();
    for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), gcount[i], 4);
    chk("fair_gap_ok", maxgap <= 2, 1);

    // saturate the conflict counter: all write the same address
    for (int t = 0; t < 10; t++) begin
      cyc(); for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'd9, DW'(t * 4 + i));
    end
    cyc(); clr(); #1;
    chk("sat_cnt", conflict_cnt, 7);

    // reset mid-operation
    cyc(); set_req(0, 1'b0, 4'd5, 8'h00); #1;
    chk("mid_gnt", gnt, 4'b0001);
    cyc(); clr(); rst_n = 1'b0; #1;
    chk("mid_gnt_rst", gnt, 0);
    chk("mid_rv_before", rvalid, 4'b0001);
    cyc(); #1;
    chk("mid_rv_after", rvalid, 0);
    chk("mid_cnt", conflict_cnt, 0);
    rst_n = 1'b1;
    cyc(); for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 8'h00); #1;
    chk("mid_ptr0", gnt, 4'b0011);
    cyc(); clr();
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
